// File: rtl/btc_host_pkg.sv
// Shared definitions for the miner ASIC host driver.
//  - state_e    : controller state encoding
//  - HASH_BYTES : bytes returned by the chip per hash
//  - NONCE_BYTES: nonce bytes appended to the stored header
//  - LZ_W       : width of a leading-zero count (0..256)
//  - hash_le    : reorders a captured hash (byte0 in the top byte) into its
//                 little-endian numeric value (byte31 in the top byte)
package btc_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_READ  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  localparam int HASH_BYTES  = 32;
  localparam int NONCE_BYTES = 4;
  localparam int LZ_W        = 9;

  function automatic logic [255:0] hash_le(input logic [255:0] h);
    logic [255:0] r;
    r = {<<8{h}};
    return r;
  endfunction

endpackage

// File: rtl/btc_lzc256.sv
// Combinational 256-bit leading-zero counter.
// Ports:
//  vec_i : value to score, bit 255 is the most significant
//  lz_o  : number of zero bits above the highest set bit; 256 when vec_i == 0
module btc_lzc256
  import btc_host_pkg::*;
(
  input  logic [255:0]     vec_i,
  output logic [LZ_W-1:0]  lz_o
);

  // Scan upwards so the highest set bit is the last one to write the count.
  always_comb begin
    lz_o = 9'd256;
    for (int i = 0; i < 256; i++) begin
      if (vec_i[i]) begin
        lz_o = 9'(255 - i);
      end else begin
        lz_o = lz_o;
      end
    end
  end

endmodule

// File: rtl/btc_host_driver.sv
// Host-side master for the miner ASIC byte handshake.
// Streams a block header (stored bytes plus a little-endian nonce) to the chip
// on request, collects the 32-byte hash it returns, scores the hash by leading
// zeros and reports a hit.
//
// Optional feature macro: NONCE_SWEEP_EN
//  defined   : after a miss the nonce increments (wrapping) and another hash is
//              started, until a hit or nonce == nonce_end_i
//  undefined : one hash per go_i, nonce_end_i unused
//
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  hdr_we_i/addr/wdata header byte write port (dropped while busy)
//  nonce_start_i       first nonce, latched on go
//  nonce_end_i         last nonce of a sweep
//  target_zeros_i      leading zero bits required for a hit (0..256)
//  go_i                start a job (sampled in IDLE only)
//  busy_o              job in progress
//  result_valid_o      one-cycle pulse per finished hash or timeout abort
//  hit_o               qualifies result_valid_o
//  err_o               timeout abort, sticky until the next go
//  nonce_out_o         nonce of the reported hash
//  hash_out_o          captured hash, byte0 in [255:248]
//  chip_start_o/rdy_o/data_o   host -> ASIC handshake
//  chip_rq_i/done_i/hash_i     ASIC -> host handshake
module btc_host_driver
  import btc_host_pkg::*;
#(
  parameter int HDR_BYTES      = 80,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hdr_we_i,
  input  logic [6:0]    hdr_addr_i,
  input  logic [7:0]    hdr_wdata_i,
  input  logic [31:0]   nonce_start_i,
  input  logic [31:0]   nonce_end_i,
  input  logic [8:0]    target_zeros_i,
  input  logic          go_i,
  output logic          busy_o,
  output logic          result_valid_o,
  output logic          hit_o,
  output logic          err_o,
  output logic [31:0]   nonce_out_o,
  output logic [255:0]  hash_out_o,
  output logic          chip_start_o,
  output logic          chip_rdy_o,
  output logic [7:0]    chip_data_o,
  input  logic          chip_rq_i,
  input  logic          chip_done_i,
  input  logic [7:0]    chip_hash_i
);

  localparam int STORE_BYTES = HDR_BYTES - NONCE_BYTES;
  localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       hdr_q [STORE_BYTES];
  state_e           state_q, state_d;
  logic [6:0]       k_q, k_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      nonce_q, nonce_d;
  logic [255:0]     hash_q, hash_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic [31:0]      nonce_out_q, nonce_out_d;
  logic             start_q, start_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       data_q, data_d;

  logic             xfer_s;
  logic             tmo_hit_s;
  logic             hit_now_s;
  logic [LZ_W-1:0]  lz_s;
  logic [255:0]     lz_vec_s;
  logic [7:0]       hidx_s;
  logic [1:0]       nonce_idx_s;
  logic [7:0]       feed_byte_s;

  assign xfer_s    = chip_rq_i & rdy_q;
  assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  // Hash byte k lands in the k-th byte from the top: bit offset (31-k)*8.
  assign hidx_s      = {~k_q[4:0], 3'b000};
  assign nonce_idx_s = 2'(k_d - 7'(STORE_BYTES));
  assign lz_vec_s    = hash_le(hash_q);
  assign hit_now_s   = (lz_s >= target_zeros_i);

  btc_lzc256 u_lzc (
    .vec_i (lz_vec_s),
    .lz_o  (lz_s)
  );

`ifdef NONCE_SWEEP_EN
  logic last_nonce_s;
  assign last_nonce_s = (nonce_q == nonce_end_i);
`else
  logic nonce_end_unused_s;
  assign nonce_end_unused_s = ^nonce_end_i;
`endif

  // Header byte store: writable only while idle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STORE_BYTES; i++) begin
        hdr_q[i] <= 8'h00;
      end
    end else if (hdr_we_i && (state_q == ST_IDLE) && (hdr_addr_i < 7'(STORE_BYTES))) begin
      hdr_q[hdr_addr_i] <= hdr_wdata_i;
    end
  end

  // Byte presented to the chip for feed index k_d: header, then nonce LE, then zeros.
  always_comb begin
    feed_byte_s = 8'h00;
    if (k_d < 7'(STORE_BYTES)) begin
      feed_byte_s = hdr_q[k_d];
    end else if (k_d < 7'(HDR_BYTES)) begin
      case (nonce_idx_s)
        2'd0:    feed_byte_s = nonce_q[7:0];
        2'd1:    feed_byte_s = nonce_q[15:8];
        2'd2:    feed_byte_s = nonce_q[23:16];
        2'd3:    feed_byte_s = nonce_q[31:24];
        default: feed_byte_s = 8'h00;
      endcase
    end else begin
      feed_byte_s = 8'h00;
    end
  end

  // Data only changes with k, so it is stable from rdy rise to the transfer edge.
  assign data_d = (state_d == ST_FEED) ? feed_byte_s : 8'h00;

  // Controller state register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 7'd0;
      tmo_q       <= '0;
      nonce_q     <= 32'h0;
      hash_q      <= 256'h0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      nonce_out_q <= 32'h0;
      start_q     <= 1'b0;
      rdy_q       <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tmo_q       <= tmo_d;
      nonce_q     <= nonce_d;
      hash_q      <= hash_d;
      busy_q      <= busy_d;
      rv_q        <= rv_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      nonce_out_q <= nonce_out_d;
      start_q     <= start_d;
      rdy_q       <= rdy_d;
      data_q      <= data_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tmo_d       = tmo_q;
    nonce_d     = nonce_q;
    hash_d      = hash_q;
    rv_d        = 1'b0;
    hit_d       = 1'b0;
    err_d       = err_q;
    nonce_out_d = nonce_out_q;
    start_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go_i) begin
          nonce_d = nonce_start_i;
          err_d   = 1'b0;
          k_d     = 7'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        k_d = 7'd0;
        if (!chip_done_i) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = ST_FEED;
        end else begin
          state_d = ST_START;
        end
      end

      ST_FEED: begin
        // Done takes priority: a coincident request belongs to the hash phase.
        if (chip_done_i) begin
          k_d     = 7'd0;
          tmo_d   = '0;
          state_d = ST_READ;
        end else if (xfer_s) begin
          k_d   = (k_q < 7'(HDR_BYTES)) ? (k_q + 7'd1) : k_q;
          tmo_d = '0;
        end else if (tmo_hit_s) begin
          err_d       = 1'b1;
          rv_d        = 1'b1;
          nonce_out_d = nonce_q;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_READ: begin
        if (xfer_s) begin
          hash_d[hidx_s +: 8] = chip_hash_i;
          tmo_d = '0;
          if (k_q == 7'(HASH_BYTES - 1)) begin
            state_d = ST_CHECK;
          end else begin
            k_d = k_q + 7'd1;
          end
        end else if (tmo_hit_s) begin
          err_d       = 1'b1;
          rv_d        = 1'b1;
          nonce_out_d = nonce_q;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_CHECK: begin
        rv_d        = 1'b1;
        hit_d       = hit_now_s;
        nonce_out_d = nonce_q;
`ifdef NONCE_SWEEP_EN
        if (!hit_now_s && !last_nonce_s) begin
          nonce_d = nonce_q + 32'd1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    // rdy is a single-cycle answer to rq, only offered while transferring.
    rdy_d  = chip_rq_i & ~rdy_q & ((state_d == ST_FEED) || (state_d == ST_READ));
  end

  assign busy_o         = busy_q;
  assign result_valid_o = rv_q;
  assign hit_o          = hit_q;
  assign err_o          = err_q;
  assign nonce_out_o    = nonce_out_q;
  assign hash_out_o     = hash_q;
  assign chip_start_o   = start_q;
  assign chip_rdy_o     = rdy_q;
  assign chip_data_o    = data_q;

endmodule

// File: tb/tb_btc_host_driver.sv
module tb_btc_host_driver;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hdr_we = 1'b0;
  logic [6:0]   hdr_addr = 7'd0;
  logic [7:0]   hdr_wdata = 8'h00;
  logic [31:0]  nonce_start = 32'h0;
  logic [31:0]  nonce_end = 32'h0;
  logic [8:0]   target_zeros = 9'd0;
  logic         go = 1'b0;
  logic         busy, result_valid, hit, err;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;
  logic         chip_start, chip_rdy;
  logic [7:0]   chip_data;
  logic         chip_rq = 1'b0;
  logic         chip_done = 1'b0;
  logic [7:0]   chip_hash = 8'h00;

  btc_host_driver #(.HDR_BYTES(80), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_we_i(hdr_we), .hdr_addr_i(hdr_addr), .hdr_wdata_i(hdr_wdata),
    .nonce_start_i(nonce_start), .nonce_end_i(nonce_end),
    .target_zeros_i(target_zeros), .go_i(go),
    .busy_o(busy), .result_valid_o(result_valid), .hit_o(hit), .err_o(err),
    .nonce_out_o(nonce_out), .hash_out_o(hash_out),
    .chip_start_o(chip_start), .chip_rdy_o(chip_rdy), .chip_data_o(chip_data),
    .chip_rq_i(chip_rq), .chip_done_i(chip_done), .chip_hash_i(chip_hash)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int extra = 0;
  int rdy_long = 0;

  typedef struct {
    logic         hit;
    logic [31:0]  nonce;
    logic         err;
    logic         chk_hash;
    logic [255:0] hash;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] hdr_m   [76];
  logic [7:0] hb      [32];
  logic [7:0] hb_p1   [32];
  logic [7:0] hb_hit  [32];
  logic [7:0] hb_miss [32];
  logic [7:0] rx      [80];
  int         rx_cnt = 0;
  int         rcnt = 0;
  int         phase = 0;
  int         mode_coincide = 0;
  int         mode_stall = 0;
  int         sel_by_nonce = 0;
  logic [31:0] hit_nonce = 32'h0;
  logic        rdy_prev = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_hash(input logic [7:0] a [32]);
    logic [255:0] h;
    h = 256'h0;
    for (int j = 0; j < 32; j++) h = {h[247:0], a[j]};
    return h;
  endfunction

  task automatic push_exp(input logic h, input logic [31:0] n, input logic e,
                          input logic ch, input logic [255:0] hv);
    exp_t x;
    x.hit = h; x.nonce = n; x.err = e; x.chk_hash = ch; x.hash = hv;
    sb_q.push_back(x);
  endtask

  task automatic start_job(input logic [31:0] n, input logic [8:0] t);
    nonce_start = n;
    target_zeros = t;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0 && busy === 1'b0) break;
    end
    chk(tag, {255'd0, (sb_q.size() == 0 && busy === 1'b0)}, 256'd1);
  endtask

  task automatic chk_rx(input string tag, input logic [31:0] n);
    int errs;
    errs = 0;
    for (int i = 0; i < 76; i++) if (rx[i] !== hdr_m[i]) errs++;
    for (int i = 0; i < 4; i++) if (rx[76+i] !== n[8*i +: 8]) errs++;
    chk(tag, 256'(errs), 256'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ASIC model: reacts on the falling edge so its inputs are stable at each rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; chip_rq = 1'b0; chip_done = 1'b0; rdy_prev = 1'b0;
    end else begin
      if (chip_rdy && rdy_prev) rdy_long++;
      rdy_prev = chip_rdy;
      case (phase)
        0: if (chip_start) begin phase = (mode_stall != 0) ? 3 : 1; rx_cnt = 0; end
        1: begin
          if (chip_rq && chip_rdy) begin
            if (rx_cnt < 80) rx[rx_cnt] = chip_data;
            rx_cnt++;
          end else if (rx_cnt < 80) chip_rq = 1'b1;
          else begin chip_rq = 1'b0; phase = 4; end
        end
        4: begin
          if (sel_by_nonce != 0) begin
            if ({rx[79], rx[78], rx[77], rx[76]} == hit_nonce) hb = hb_hit;
            else hb = hb_miss;
          end
          rcnt = 0;
          chip_hash = hb[0];
          chip_done = 1'b1;
          chip_rq = (mode_coincide != 0);
          phase = 2;
        end
        2: begin
          if (chip_rq && chip_rdy) rcnt++;
          else if (rcnt < 32) begin chip_hash = hb[rcnt]; chip_rq = 1'b1; end
          else begin chip_rq = 1'b0; chip_done = 1'b0; phase = 0; end
        end
        3: begin chip_rq = 1'b0; if (!busy) phase = 0; end
        default: phase = 0;
      endcase
    end
  end

  // Scoreboard consumer: every reported result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb_q.size() == 0) extra++;
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_hit", {255'd0, hit}, {255'd0, e.hit});
        chk("res_nonce", 256'(nonce_out), 256'(e.nonce));
        chk("res_err", {255'd0, err}, {255'd0, e.err});
        if (e.chk_hash) chk("res_hash", hash_out, e.hash);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    for (int i = 0; i < 32; i++) begin
      hb_p1[i] = 8'($urandom_range(1, 255));
      hb_hit[i] = 8'h00;
      hb_miss[i] = 8'hFF;
    end
    hb_p1[31] = 8'h00;
    hb_p1[30] = 8'h0F;
    hb_hit[0] = 8'h01;
    for (int i = 0; i < 76; i++) hdr_m[i] = 8'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_rv_hit_err", {253'd0, result_valid, hit, err}, 256'd0);
    chk("rst_chip", {246'd0, chip_start, chip_rdy, chip_data}, 256'd0);
    chk("rst_nonce_out", 256'(nonce_out), 256'd0);
    chk("rst_hash", hash_out, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 76; i++) begin
      hdr_we = 1'b1; hdr_addr = 7'(i); hdr_wdata = hdr_m[i];
      @(negedge clk);
    end
    hdr_we = 1'b0;

    // Job A: lz=12, target 12 -> hit; go and header write while busy are dropped
    hb = hb_p1;
    push_exp(1'b1, 32'h12345678, 1'b0, 1'b1, mk_hash(hb_p1));
    start_job(32'h12345678, 9'd12);
    repeat (20) @(negedge clk);
    nonce_start = 32'hFFFFFFFF;
    go = 1'b1; hdr_we = 1'b1; hdr_addr = 7'd0; hdr_wdata = ~hdr_m[0];
    @(negedge clk);
    go = 1'b0; hdr_we = 1'b0;
    wait_done("jobA_done");
    chk_rx("jobA_stream", 32'h12345678);
    chk("jobA_err", {255'd0, err}, 256'd0);

    // Job B: same hash, target 13 -> miss
    push_exp(1'b0, 32'hDEADBEEF, 1'b0, 1'b1, mk_hash(hb_p1));
    start_job(32'hDEADBEEF, 9'd13);
    wait_done("jobB_done");
    chk_rx("jobB_stream", 32'hDEADBEEF);

    // Job C: done and rq rise together -> first transfer is hash byte 0
    mode_coincide = 1;
    push_exp(1'b1, 32'h00000001, 1'b0, 1'b1, mk_hash(hb_p1));
    start_job(32'h00000001, 9'd12);
    wait_done("jobC_done");
    mode_coincide = 0;

    // Job C2: all-zero hash scores 256, target 256 -> hit
    hb = hb_hit; hb[0] = 8'h00;
    push_exp(1'b1, 32'h00000002, 1'b0, 1'b1, 256'd0);
    start_job(32'h00000002, 9'd256);
    wait_done("jobC2_done");

    // Timeout: chip never requests
    mode_stall = 1;
    push_exp(1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 256'd0);
    start_job(32'hA5A5A5A5, 9'd0);
    for (int i = 0; i < 50 && !chip_start; i++) @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 100 && !result_valid; i++) @(negedge clk);
    t1 = cyc;
    chk("timeout_latency", 256'(t1 - t0), 256'd16);
    wait_done("timeout_done");
    chk("err_sticky", {255'd0, err}, 256'd1);
    chk("rdy_low_after_abort", {255'd0, chip_rdy}, 256'd0);
    mode_stall = 0;

    // Job D: all-FF hash, target 0 -> hit; go clears err
    hb = hb_miss;
    push_exp(1'b1, 32'h00000000, 1'b0, 1'b1, mk_hash(hb_miss));
    start_job(32'h00000000, 9'd0);
    chk("err_cleared_by_go", {255'd0, err}, 256'd0);
    wait_done("jobD_done");
    chk_rx("jobD_stream", 32'h00000000);

    // Reset mid-FEED, then a clean job with the cleared header
    hb = hb_p1;
    start_job(32'h55667788, 9'd12);
    for (int i = 0; i < 500 && rx_cnt < 10; i++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_rv", {254'd0, busy, result_valid}, 256'd0);
    chk("midrst_chip", {246'd0, chip_start, chip_rdy, chip_data}, 256'd0);
    chk("midrst_hash", hash_out, 256'd0);
    for (int i = 0; i < 76; i++) hdr_m[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(1'b1, 32'h0BADF00D, 1'b0, 1'b1, mk_hash(hb_p1));
    start_job(32'h0BADF00D, 9'd12);
    wait_done("jobE_done");
    chk_rx("jobE_stream", 32'h0BADF00D);

    // Nonce sweep 5..8 with the only hit at nonce 7
    sel_by_nonce = 1;
    hit_nonce = 32'd7;
    nonce_end = 32'd8;
    push_exp(1'b0, 32'd5, 1'b0, 1'b1, mk_hash(hb_miss));
`ifdef NONCE_SWEEP_EN
    push_exp(1'b0, 32'd6, 1'b0, 1'b1, mk_hash(hb_miss));
    push_exp(1'b1, 32'd7, 1'b0, 1'b1, mk_hash(hb_hit));
`endif
    start_job(32'd5, 9'd12);
    wait_done("sweep_done");
    sel_by_nonce = 0;

    repeat (5) @(negedge clk);
    chk("rdy_pulse_width", 256'(rdy_long), 256'd0);
    chk("no_extra_results", 256'(extra), 256'd0);
    chk("scoreboard_empty", 256'(sb_q.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
